// File: rtl/i2c_read_data.sv
// i2c_read_data: I2C master read engine (START, address+R, N_BYTES reads MSB-first, ACK/NACK, STOP).
module i2c_read_data #(
  parameter int N_BYTES = 2
) (
  input  logic                 PT_CK,
  input  logic                 RESET,
  input  logic                 GO,
  input  logic [7:0]           SLAVE_ADDRESS,
  input  logic                 SDAI,
  output logic                 SDAO,
  output logic                 SCLO,
  output logic                 END_OK,
  output logic                 ACK_OK,
  output logic [8*N_BYTES-1:0] DATA,
  output logic [4:0]           ST
);
  localparam int DW = 8 * N_BYTES;
  localparam logic [2:0] LAST = 3'(N_BYTES);
  typedef enum logic [4:0] {
    S_IDLE, S_STA_A, S_STA_B, S_BIT_LO, S_BIT_HI, S_BIT_SMP, S_STP_A, S_STP_B, S_STP_C
  } state_t;
  state_t state_q, state_d;
  logic [3:0] bit_q, bit_d;
  logic [2:0] byte_q, byte_d;
  logic [DW-1:0] shift_q, shift_d, data_q, data_d;
  logic go_q, ack_q, ack_d, sda_q, sda_d, scl_q, scl_d, tx_bit;
  logic [7:0] addr_byte;
  assign addr_byte = SLAVE_ADDRESS | 8'h01;
  always_comb begin
    state_d = state_q;
    bit_d = bit_q;
    byte_d = byte_q;
    shift_d = shift_q;
    data_d = data_q;
    ack_d = ack_q;
    case (state_q)
      S_IDLE: if (GO && !go_q) begin
        state_d = S_STA_A;
        ack_d = 1'b0;
        bit_d = 4'd0;
        byte_d = 3'd0;
      end
      S_STA_A: state_d = S_STA_B;
      S_STA_B: state_d = S_BIT_LO;
      S_BIT_LO: state_d = S_BIT_HI;
      S_BIT_HI: begin
        state_d = S_BIT_SMP;
        if (byte_q == 3'd0) begin
          if (bit_q == 4'd8) ack_d = !SDAI;
        end else if (bit_q != 4'd8) shift_d = {shift_q[DW-2:0], SDAI};
      end
      S_BIT_SMP: if (bit_q != 4'd8) begin
        bit_d = bit_q + 4'd1;
        state_d = S_BIT_LO;
      end else if ((byte_q == 3'd0 && !ack_q) || byte_q == LAST) begin
        state_d = S_STP_A;
        if (ack_q) data_d = shift_q;
      end else begin
        bit_d = 4'd0;
        byte_d = byte_q + 3'd1;
        state_d = S_BIT_LO;
      end
      S_STP_A: state_d = S_STP_B;
      S_STP_B: state_d = S_STP_C;
      default: state_d = S_IDLE;
    endcase
  end
  // Byte 0 is the address phase; data bytes release SDA and ACK all but the last.
  always_comb begin
    tx_bit = (byte_d == 3'd0) ? (bit_d[3] | addr_byte[~bit_d[2:0]])
                              : (bit_d[3] ? (byte_d == LAST) : 1'b1);
    sda_d = (state_d == S_IDLE || state_d == S_STP_C) ? 1'b1 :
            (state_d == S_BIT_LO || state_d == S_BIT_HI || state_d == S_BIT_SMP) ? tx_bit : 1'b0;
    scl_d = state_d == S_IDLE || state_d == S_STA_A || state_d == S_BIT_HI ||
            state_d == S_STP_B || state_d == S_STP_C;
  end
  always_ff @(posedge PT_CK) begin
    if (RESET) begin
      state_q <= S_IDLE;
      bit_q <= 4'd0;
      byte_q <= 3'd0;
      shift_q <= '0;
      data_q <= '0;
      ack_q <= 1'b0;
      go_q <= 1'b1;
      sda_q <= 1'b1;
      scl_q <= 1'b1;
    end else begin
      state_q <= state_d;
      bit_q <= bit_d;
      byte_q <= byte_d;
      shift_q <= shift_d;
      data_q <= data_d;
      ack_q <= ack_d;
      go_q <= GO;
      sda_q <= sda_d;
      scl_q <= scl_d;
    end
  end
  assign SDAO = sda_q;
  assign SCLO = scl_q;
  assign END_OK = state_q == S_IDLE;
  assign ACK_OK = ack_q;
  assign DATA = data_q;
  assign ST = state_q;
endmodule
